// File: rtl/bus_out_accum.sv
// Frame accumulator for the bus_out/eee sample stream, with a small result FIFO.
// Optional saturating arithmetic and per-entry out_sat flag under BUS_OUT_ACCUM_SAT_EN.
module bus_out_accum #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ACC_W-1:0]  in_bias,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_partial,
`ifdef BUS_OUT_ACCUM_SAT_EN
  output logic              out_sat,
`endif
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [8:0]         cnt_inc;
  logic [ACC_W-1:0]   add_a, ext, sum;
  logic               push, push_part;
  logic [ACC_W-1:0]   push_val;

  logic [ACC_W-1:0]   mem_data [FIFO_DEPTH];
  logic               mem_part [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      occ_q;
  logic               full, pop, wr_en, drop;

  // First sample of a frame rides on the bias; later samples on the running sum.
  assign add_a   = (state_q == IDLE) ? in_bias : acc_q;
  assign ext     = {{(ACC_W-DATA_W){1'b0}}, in_data};
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

`ifdef BUS_OUT_ACCUM_SAT_EN
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  logic sum_ovf, sat_q, push_sat;
  logic mem_sat [FIFO_DEPTH];

  assign {sum_ovf, sum} = sat_add(add_a, ext);
  assign push_sat = (state_q == IDLE) ? sum_ovf :
                    (in_valid ? (sat_q | sum_ovf) : sat_q);

  always_ff @(posedge clk) begin
    if (rst)           sat_q <= 1'b0;
    else if (in_valid) sat_q <= push_sat;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_sat[wr_q] <= push_sat;
  end

  assign out_sat = out_valid & mem_sat[rd_q];
`else
  assign sum = add_a + ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_part = 1'b0;
    push_val  = sum;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = 8'd1;
          if (FRAME_LEN == 1) push = 1'b1;
          else                state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_inc[7:0];
          if (cnt_inc == 9'(FRAME_LEN)) begin
            push    = 1'b1;
            state_d = IDLE;
          end else if (flush) begin
            push      = 1'b1;
            push_part = 1'b1;
            state_d   = IDLE;
          end
        end else if (flush) begin
          push      = 1'b1;
          push_part = 1'b1;
          push_val  = acc_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // A push into a full FIFO is still accepted when the head pops the same cycle.
  assign full  = (occ_q == CW'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      occ_q    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (pop)   rd_q <= rd_q + PW'(1);
      if (wr_en && !pop)      occ_q <= occ_q + CW'(1);
      else if (!wr_en && pop) occ_q <= occ_q - CW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_q] <= push_val;
      mem_part[wr_q] <= push_part;
    end
  end

  assign out_valid   = (occ_q != '0);
  assign out_data    = out_valid ? mem_data[rd_q] : '0;
  assign out_partial = out_valid & mem_part[rd_q];

endmodule

// File: tb/tb_bus_out_accum.sv
// Directed bench for bus_out_accum: frames, flush, FIFO full/drop, reset, wrap or saturate.
module tb_bus_out_accum;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [15:0] in_data;
  logic [31:0] in_bias;
  logic        out_valid, out_partial, busy, overflow;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;
`ifdef BUS_OUT_ACCUM_SAT_EN
  logic        out_sat;
`endif

  int vec = 0;
  int err = 0;

  bus_out_accum #(.DATA_W(16), .ACC_W(32), .FRAME_LEN(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_bias(in_bias),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_partial(out_partial),
`ifdef BUS_OUT_ACCUM_SAT_EN
    .out_sat(out_sat),
`endif
    .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [31:0] b, input logic f);
    in_valid = v;
    in_data  = d;
    in_bias  = b;
    flush    = f;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [31:0] b);
    drive(1'b1, 16'd1, b, 1'b0);
    drive(1'b1, 16'd2, 32'h0, 1'b0);
    drive(1'b1, 16'd3, 32'h0, 1'b0);
    drive(1'b1, 16'd4, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bias = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);

    // Basic frame: 100+1+2+3+4
    out_ready = 1'b1;
    drive(1'b1, 16'd1, 32'd100, 1'b0);
    chk("basic_busy_mid", {31'b0, busy}, 32'd1);
    chk("basic_no_early", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 16'd2, 32'd0, 1'b0);
    drive(1'b1, 16'd3, 32'd0, 1'b0);
    drive(1'b1, 16'd4, 32'd0, 1'b0);
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_data", out_data, 32'd110);
    chk("basic_partial", {31'b0, out_partial}, 32'd0);
    chk("basic_busy_end", {31'b0, busy}, 32'd0);
    idle();
    chk("basic_popped", {31'b0, out_valid}, 32'd0);

    // Flush of a two-sample frame, then flush in IDLE does nothing
    drive(1'b1, 16'hFFFF, 32'd0, 1'b0);
    drive(1'b1, 16'h0001, 32'd0, 1'b0);
    drive(1'b0, 16'h0, 32'd0, 1'b1);
    chk("flush_valid", {31'b0, out_valid}, 32'd1);
    chk("flush_data", out_data, 32'h10000);
    chk("flush_partial", {31'b0, out_partial}, 32'd1);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    idle();
    drive(1'b0, 16'h0, 32'd0, 1'b1);
    idle();
    chk("flush_idle_novalid", {31'b0, out_valid}, 32'd0);
    chk("flush_idle_busy", {31'b0, busy}, 32'd0);

    // FIFO full: six frames 10..60 with no consumer
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) frame(32'(10*k - 10));
    chk("full_head", out_data, 32'd10);
    chk("full_ovf", {31'b0, overflow}, 32'd1);
    chk("full_drop", {24'b0, drop_cnt}, 32'd2);
    chk("full_busy", {31'b0, busy}, 32'd0);
    drive(1'b0, 16'h0, 32'd0, 1'b0);
    chk("full_hold", out_data, 32'd10);

    // Full FIFO, frame 70 completes on the same edge as a pop
    drive(1'b1, 16'd1, 32'd60, 1'b0);
    drive(1'b1, 16'd2, 32'd0, 1'b0);
    drive(1'b1, 16'd3, 32'd0, 1'b0);
    out_ready = 1'b1;
    drive(1'b1, 16'd4, 32'd0, 1'b0);
    out_ready = 1'b0;
    chk("simul_drop", {24'b0, drop_cnt}, 32'd2);
    chk("simul_head", out_data, 32'd20);
    out_ready = 1'b1;
    chk("drain_0", out_data, 32'd20); idle();
    chk("drain_1", out_data, 32'd30); idle();
    chk("drain_2", out_data, 32'd40); idle();
    chk("drain_3", out_data, 32'd70);
    chk("drain_3_valid", {31'b0, out_valid}, 32'd1); idle();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);
    idle();
    chk("pop_empty_ignored", {31'b0, out_valid}, 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Flush coinciding with the last sample is a complete frame
    drive(1'b1, 16'd1, 32'd0, 1'b0);
    drive(1'b1, 16'd2, 32'd0, 1'b0);
    drive(1'b1, 16'd3, 32'd0, 1'b0);
    drive(1'b1, 16'd4, 32'd0, 1'b1);
    chk("flush_last_data", out_data, 32'd10);
    chk("flush_last_partial", {31'b0, out_partial}, 32'd0);
    idle();
    // Flush with the second sample includes that sample
    drive(1'b1, 16'd5, 32'd7, 1'b0);
    drive(1'b1, 16'd6, 32'd0, 1'b1);
    chk("flush_incl_data", out_data, 32'd18);
    chk("flush_incl_partial", {31'b0, out_partial}, 32'd1);
    chk("flush_incl_busy", {31'b0, busy}, 32'd0);
    idle();
    chk("flush_incl_popped", {31'b0, out_valid}, 32'd0);

    // Reset mid-frame with two queued entries
    out_ready = 1'b0;
    frame(32'd0);
    frame(32'd0);
    drive(1'b1, 16'd1, 32'd0, 1'b0);
    drive(1'b1, 16'd2, 32'd0, 1'b0);
    in_valid = 1'b0; in_data = '0; in_bias = '0; flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_ovf", {31'b0, overflow}, 32'd0);
    chk("mrst_drop", {24'b0, drop_cnt}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 16'd1, 32'd5, 1'b0);
    drive(1'b1, 16'd1, 32'd0, 1'b0);
    drive(1'b1, 16'd1, 32'd0, 1'b0);
    drive(1'b1, 16'd1, 32'd0, 1'b0);
    chk("mrst_frame", out_data, 32'd9);
    chk("mrst_partial", {31'b0, out_partial}, 32'd0);
    idle();
    chk("mrst_only_one", {31'b0, out_valid}, 32'd0);

    // Wrap (or saturate) past 2^32
    drive(1'b1, 16'h20, 32'hFFFF_FFF0, 1'b0);
    drive(1'b1, 16'h20, 32'd0, 1'b0);
    drive(1'b1, 16'h20, 32'd0, 1'b0);
    drive(1'b1, 16'h20, 32'd0, 1'b0);
`ifdef BUS_OUT_ACCUM_SAT_EN
    chk("sat_data", out_data, 32'hFFFF_FFFF);
    chk("sat_flag", {31'b0, out_sat}, 32'd1);
`else
    chk("wrap_data", out_data, 32'h70);
`endif
    chk("wrap_valid", {31'b0, out_valid}, 32'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
